// File: rtl/sharing_chk_pkg.sv
// Shared types and constants for the logic_with_sharing response checker.
// Mismatch record layout, LSB first: got, exp, vec, then the vector index on top.
package sharing_chk_pkg;

  localparam int VEC_W = 6;
  localparam int RSP_W = 2;

  localparam int REC_GOT_LSB = 0;
  localparam int REC_EXP_LSB = REC_GOT_LSB + RSP_W;
  localparam int REC_VEC_LSB = REC_EXP_LSB + RSP_W;
  localparam int REC_IDX_LSB = REC_VEC_LSB + VEC_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VEC,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } chk_state_t;

  // Fixed-width part of a mismatch record; the index is prepended by the checker.
  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [RSP_W-1:0] exp;
    logic [RSP_W-1:0] got;
  } rec_body_t;

endpackage

// File: rtl/sharing_chk_log_fifo.sv
// First-word-fall-through FIFO for mismatch records.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module sharing_chk_log_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  // The extra pointer bit tells full (MSBs differ) from empty (pointers equal).
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sharing_response_checker.sv
// Drives stimulus vectors into logic_with_sharing, samples x/y after a settle
// time, counts vectors/mismatches and logs mismatch records for the host.
module sharing_response_checker
  import sharing_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOG_DEPTH     = 8,
  parameter int CNT_W         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         vec_valid,
  output logic                         vec_ready,
  input  logic [VEC_W-1:0]             vec_data,
  input  logic [RSP_W-1:0]             vec_exp,
  input  logic                         vec_last,
  output logic [VEC_W-1:0]             stim,
  input  logic                         dut_x,
  input  logic                         dut_y,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [CNT_W-1:0]             vec_count,
  output logic [CNT_W-1:0]             err_count,
  output logic                         log_valid,
  input  logic                         log_ready,
  output logic [CNT_W+VEC_W+2*RSP_W-1:0] log_data,
  output logic                         log_ovf
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  chk_state_t       state, state_nx;
  logic [3:0]       settle_cnt;
  logic [VEC_W-1:0] stim_q;
  logic [RSP_W-1:0] exp_q;
  logic             last_q;
  logic [CNT_W-1:0] vec_cnt, err_cnt;
  logic             ovf_q;
  logic             hs, clr, mismatch, drop, log_empty, log_full;
  logic [RSP_W-1:0] got;
  rec_body_t        rec;

  assign got      = {dut_x, dut_y};
  assign hs       = vec_valid && vec_ready;
  assign clr      = start && (state == ST_IDLE || state == ST_DONE);
  assign mismatch = (state == ST_COMPARE) && (got != exp_q);
  assign rec      = '{vec: stim_q, exp: exp_q, got: got};

  always_comb begin
    state_nx  = state;
    vec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE:     if (start) state_nx = ST_WAIT_VEC;
      ST_WAIT_VEC: begin
        vec_ready = 1'b1;
        busy      = 1'b1;
        if (vec_valid) state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_nx = ST_COMPARE;
      end
      ST_COMPARE: begin
        busy     = 1'b1;
        state_nx = last_q ? ST_DONE : ST_WAIT_VEC;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nx = ST_WAIT_VEC;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      stim_q     <= '0;
      exp_q      <= '0;
      last_q     <= 1'b0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr) begin
        vec_cnt <= '0;
        err_cnt <= '0;
        ovf_q   <= 1'b0;
      end
      // Load SETTLE_CYCLES-1 so COMPARE is entered exactly SETTLE_CYCLES edges after the handshake.
      if (hs) begin
        stim_q     <= vec_data;
        exp_q      <= vec_exp;
        last_q     <= vec_last;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (state == ST_COMPARE) begin
        if (vec_cnt != '1)              vec_cnt <= vec_cnt + CNT_W'(1);
        if (mismatch && err_cnt != '1)  err_cnt <= err_cnt + CNT_W'(1);
        if (drop)                       ovf_q   <= 1'b1;
      end
    end
  end

  sharing_chk_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .W     (CNT_W + VEC_W + 2*RSP_W)
  ) u_log (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (mismatch),
    .din   ({vec_cnt, rec}),
    .pop   (log_ready),
    .dout  (log_data),
    .full  (log_full),
    .empty (log_empty),
    .drop  (drop)
  );

  assign stim      = stim_q;
  assign vec_count = vec_cnt;
  assign err_count = err_cnt;
  assign pass      = done && (err_cnt == '0);
  assign log_valid = !log_empty;
  assign log_ovf   = ovf_q;

endmodule

// File: tb/tb_sharing_response_checker.sv
// Directed bench: a behavioural stand-in for logic_with_sharing answers from stim,
// with an XOR injector to force mismatches.
module tb_sharing_response_checker;

  localparam int CW = 4, LD = 8, SC = 2, LW = CW + 10;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, vec_valid = 1'b0, vec_last = 1'b0, log_ready = 1'b0;
  logic [5:0]    vec_data = '0;
  logic [1:0]    vec_exp = '0, inj = '0;
  logic          dut_x, dut_y, vec_ready, busy, done, pass, log_valid, log_ovf;
  logic [5:0]    stim;
  logic [CW-1:0] vec_count, err_count;
  logic [LW-1:0] log_data;
  int applied = 0, miscompares = 0, hs_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] model(input logic [5:0] s);
    return {(s[5] & s[4]) | s[3], ^s[2:0]};
  endfunction

  assign {dut_x, dut_y} = model(stim) ^ inj;

  sharing_response_checker #(.SETTLE_CYCLES(SC), .LOG_DEPTH(LD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .vec_exp(vec_exp), .vec_last(vec_last), .stim(stim),
    .dut_x(dut_x), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .log_valid(log_valid),
    .log_ready(log_ready), .log_data(log_data), .log_ovf(log_ovf)
  );

  always @(posedge clk) if (!rst && vec_valid && vec_ready) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Presents a vector and returns 1ns after its handshake edge.
  task automatic send(input logic [5:0] v, input logic [1:0] e, input logic last);
    int n = 0;
    vec_data = v; vec_exp = e; vec_last = last; vec_valid = 1'b1;
    while (!vec_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("vec_ready_timeout", 0, 1);
    tick();
    vec_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin tick(); n++; end
    if (n >= 40) chk("done_timeout", 0, 1);
  endtask

  logic [5:0] t2v [4] = '{6'h2A, 6'h15, 6'h3F, 6'h00};
  logic [5:0] v;
  logic [1:0] e;
  int hs0;

  initial begin
    // reset values
    #1 rst = 1'b1; #2;
    chk("rst_stim", stim, 0);       chk("rst_vec_ready", vec_ready, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);       chk("rst_vec_count", vec_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_log_valid", log_valid, 0); chk("rst_log_ovf", log_ovf, 0);
    tick(); tick(); rst = 1'b0; tick();

    // four matching vectors, compare lands SETTLE_CYCLES after each handshake
    pulse_start();
    chk("run_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      send(t2v[i], model(t2v[i]), i == 3);
      chk("match_stim", stim, t2v[i]);
      chk("match_vec_ready_settle", vec_ready, 0);
      tick(); chk("match_cnt_t1", vec_count, i);
      tick(); chk("match_cnt_t2", vec_count, i);
      tick(); chk("match_cnt_t3", vec_count, i + 1);
    end
    chk("match_done", done, 1);      chk("match_pass", pass, 1);
    chk("match_busy", busy, 0);      chk("match_err", err_count, 0);
    chk("match_log_valid", log_valid, 0);
    chk("match_stim_hold", stim, 6'h00);

    // single mismatch and its record
    pulse_start();
    chk("start_clears_cnt", vec_count, 0);
    chk("start_clears_done", done, 0);
    inj = 2'b11;
    send(6'b000111, 2'b01, 1'b1);
    tick(); tick(); tick();
    chk("mis_done", done, 1);        chk("mis_pass", pass, 0);
    chk("mis_err", err_count, 1);    chk("mis_log_valid", log_valid, 1);
    chk("mis_log_data", log_data, {4'd0, 6'b000111, 2'b01, 2'b10});
    log_ready = 1'b1; tick(); log_ready = 1'b0;
    chk("mis_pop_empty", log_valid, 0);

    // ten mismatches into an 8-deep log with no draining
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      v = 6'(i * 7 + 1);
      send(v, model(v), i == 9);
    end
    wait_done();
    chk("ovf_err", err_count, 10);   chk("ovf_vec", vec_count, 10);
    chk("ovf_flag", log_ovf, 1);
    log_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 6'(i * 7 + 1); e = model(v);
      chk("ovf_drain_valid", log_valid, 1);
      chk("ovf_drain_rec", log_data, {4'(i), v, e, e ^ 2'b11});
      tick();
    end
    log_ready = 1'b0;
    chk("ovf_drained", log_valid, 0);

    // full log with a pop on the compare edge: push accepted, no overflow
    pulse_start();
    chk("start_clears_ovf", log_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      v = 6'(i + 40);
      send(v, model(v), 1'b0);
    end
    v = 6'h3B;
    send(v, model(v), 1'b1);
    tick(); tick();
    log_ready = 1'b1; tick(); log_ready = 1'b0;
    chk("full_pop_ovf", log_ovf, 0);
    chk("full_pop_err", err_count, 9);
    log_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("full_pop_valid", log_valid, 1);
      chk("full_pop_idx", log_data[LW-1:10], i + 1);
      tick();
    end
    log_ready = 1'b0;
    chk("full_pop_empty", log_valid, 0);
    chk("full_pop_last_vec", stim, 6'h3B);

    // reset mid-settle with a partial log
    pulse_start();
    send(6'h21, model(6'h21), 1'b0);
    tick(); tick(); tick();
    chk("mid_pre_log_valid", log_valid, 1);
    send(6'h12, model(6'h12), 1'b0);
    rst = 1'b1; #2;
    chk("mid_rst_stim", stim, 0);      chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vec_ready", vec_ready, 0);
    chk("mid_rst_done", done, 0);      chk("mid_rst_vec_count", vec_count, 0);
    chk("mid_rst_err", err_count, 0);  chk("mid_rst_log_valid", log_valid, 0);
    tick(); rst = 1'b0; inj = 2'b00; tick();
    chk("mid_idle_busy", busy, 0);

    // valid held through SETTLE, gaps, ignored start, counter saturation
    hs0 = hs_cnt;
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      v = 6'(i * 5 + 3);
      send(v, model(v), i == 16);
      chk("sat_stim", stim, v);
      if (i % 2 == 0 && i != 16) begin
        v = 6'((i + 1) * 5 + 3);
        vec_data = v; vec_exp = model(v); vec_valid = 1'b1;
        chk("sat_no_ready_settle", vec_ready, 0);
      end else begin
        if (i == 5) start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
      end
    end
    wait_done();
    chk("sat_handshakes", hs_cnt - hs0, 17);
    chk("sat_vec_count", vec_count, 15);
    chk("sat_err", err_count, 0);
    chk("sat_pass", pass, 1);
    chk("sat_log_valid", log_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
